// File: rtl/dbus_arbiter_if.sv
// Data-bus signal bundle between two requesters, the arbiter and the DMEM/UART slaves.
// master: the environment side (requesters and slave read data); slave: the arbiter itself.
interface dbus_arbiter_if;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [2:0]  m0_size;
    logic [2:0]  m1_size;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic        dmem_wr_en;
    logic        dmem_rd_en;
    logic        uart_wr_en;
    logic        uart_rd_en;
    logic [31:0] s_addr_off;
    logic [31:0] s_wdata;
    logic [2:0]  s_size;
    logic [31:0] dmem_rdata;
    logic [31:0] uart_rdata;

    modport master (
        output m_req, m_we, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_size, m1_size,
        output dmem_rdata, uart_rdata,
        input  m_gnt, m_rvalid, m_err, m_rdata,
        input  dmem_wr_en, dmem_rd_en, uart_wr_en, uart_rd_en, s_addr_off, s_wdata, s_size
    );

    modport slave (
        input  m_req, m_we, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_size, m1_size,
        input  dmem_rdata, uart_rdata,
        output m_gnt, m_rvalid, m_err, m_rdata,
        output dmem_wr_en, dmem_rd_en, uart_wr_en, uart_rd_en, s_addr_off, s_wdata, s_size
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: picks an owner, decodes DMEM/UART regions, runs a
// one-cycle slave access and returns a registered one-cycle response to the owner.
module dbus_arbiter #(
    parameter logic [31:0] DMEM_BASE  = 32'h8000_0000,
    parameter logic [31:0] DMEM_SIZE  = 32'h0000_0100,
    parameter logic [31:0] UART_BASE  = 32'h8000_0200,
    parameter logic [31:0] UART_SIZE  = 32'h0000_0100,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input logic           clk,
    input logic           reset,
    dbus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
    typedef enum logic [1:0] {RegNone, RegDmem, RegUart} region_e;

    state_e      state_q, state_d;
    region_e     region_q, region_d;
    logic        owner_q, owner_d;
    logic        ptr_q, ptr_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        winner;
    logic        launch;
    logic [1:0]  owner_oh;
    logic [31:0] sel_addr;
    logic [31:0] dmem_off;
    logic [31:0] uart_off;

    always_comb begin
        winner = 1'b0;
        unique case (bus.m_req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = FIXED_PRIO ? 1'b0 : ptr_q;
            default: winner = 1'b0;
        endcase
    end

    // An address below the base wraps to a huge offset, so one unsigned compare bounds both ends.
    assign sel_addr = winner ? bus.m1_addr : bus.m0_addr;
    assign dmem_off = sel_addr - DMEM_BASE;
    assign uart_off = sel_addr - UART_BASE;
    assign owner_oh = owner_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        we_d     = we_q;
        err_d    = err_q;
        size_d   = size_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        launch   = 1'b0;

        unique case (state_q)
            StIdle: launch = |bus.m_req;
            StAccess: begin
                state_d = StResp;
                ptr_d   = ~owner_q;
                err_d   = (region_q == RegNone);
                rdata_d = '0;
                if (!we_q && region_q == RegDmem) rdata_d = bus.dmem_rdata;
                if (!we_q && region_q == RegUart) rdata_d = bus.uart_rdata;
            end
            StResp: begin
                state_d = StIdle;
                launch  = |bus.m_req;
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d = StAccess;
            owner_d = winner;
            we_d    = winner ? bus.m_we[1] : bus.m_we[0];
            size_d  = winner ? bus.m1_size : bus.m0_size;
            wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
            if (dmem_off < DMEM_SIZE) begin
                region_d = RegDmem;
                off_d    = dmem_off;
            end else if (uart_off < UART_SIZE) begin
                region_d = RegUart;
                off_d    = uart_off;
            end else begin
                region_d = RegNone;
                off_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            region_q <= RegNone;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            err_q    <= err_d;
            size_q   <= size_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Grant and strobes decode from state alone so an async reset clears them immediately.
    always_comb begin
        bus.m_gnt      = '0;
        bus.m_rvalid   = '0;
        bus.m_err      = '0;
        bus.dmem_wr_en = 1'b0;
        bus.dmem_rd_en = 1'b0;
        bus.uart_wr_en = 1'b0;
        bus.uart_rd_en = 1'b0;
        if (state_q == StAccess) begin
            bus.m_gnt      = owner_oh;
            bus.dmem_wr_en = (region_q == RegDmem) && we_q;
            bus.dmem_rd_en = (region_q == RegDmem) && !we_q;
            bus.uart_wr_en = (region_q == RegUart) && we_q;
            bus.uart_rd_en = (region_q == RegUart) && !we_q;
        end
        if (state_q == StResp) begin
            bus.m_rvalid = owner_oh;
            if (err_q) bus.m_err = owner_oh;
        end
    end

    assign bus.m_rdata    = rdata_q;
    assign bus.s_addr_off = off_q;
    assign bus.s_wdata    = wdata_q;
    assign bus.s_size     = size_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized scoreboard bench for dbus_arbiter: round-robin instance plus a fixed-priority one.
module tb_dbus_arbiter;

    localparam logic [31:0] DB = 32'h8000_0000;
    localparam logic [31:0] DS = 32'h0000_0100;
    localparam logic [31:0] UB = 32'h8000_0200;
    localparam logic [31:0] US = 32'h0000_0100;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } txn_t;

    // strb order: {dmem_wr, dmem_rd, uart_wr, uart_rd}
    typedef struct packed {
        logic [1:0]  owner_oh;
        logic [3:0]  strb;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  size;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dbus_arbiter_if bus_rr ();
    dbus_arbiter_if bus_fp ();

    dbus_arbiter #(.DMEM_BASE(DB), .DMEM_SIZE(DS), .UART_BASE(UB), .UART_SIZE(US),
                   .FIXED_PRIO(1'b0)) u_rr (.clk(clk), .reset(reset), .bus(bus_rr.slave));
    dbus_arbiter #(.DMEM_BASE(DB), .DMEM_SIZE(DS), .UART_BASE(UB), .UART_SIZE(US),
                   .FIXED_PRIO(1'b1)) u_fp (.clk(clk), .reset(reset), .bus(bus_fp.slave));

    function automatic logic [31:0] dmem_fn(input logic [31:0] off);
        return 32'hDEAD_BEEF ^ ((off - 32'h10) * 32'h9E37_79B9);
    endfunction

    function automatic logic [31:0] uart_fn(input logic [31:0] off);
        return 32'h0A5C_3300 ^ (off * 32'h0101_0101);
    endfunction

    // Combinational slave models keyed on the offset the arbiter presents.
    assign bus_rr.dmem_rdata = dmem_fn(bus_rr.s_addr_off);
    assign bus_rr.uart_rdata = uart_fn(bus_rr.s_addr_off);
    assign bus_fp.dmem_rdata = dmem_fn(bus_fp.s_addr_off);
    assign bus_fp.uart_rdata = uart_fn(bus_fp.s_addr_off);

    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;
    exp_t sb_rr[$];
    exp_t sb_fp[$];
    txn_t q0[$];
    txn_t q1[$];
    int   ptr_m = 0;
    logic [1:0] prev_gnt [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] size);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.size = size;
        return t;
    endfunction

    // Reference model: region by plain range membership, response by region and direction.
    function automatic exp_t predict(input txn_t t, input int m);
        exp_t e;
        e.owner_oh = (m == 0) ? 2'b01 : 2'b10;
        e.wdata = t.wdata; e.size = t.size;
        e.strb = 4'b0000; e.off = '0; e.rdata = '0; e.err = 1'b0;
        if (t.addr >= DB && t.addr < DB + DS) begin
            e.off  = t.addr - DB;
            e.strb = t.we ? 4'b1000 : 4'b0100;
            if (!t.we) e.rdata = dmem_fn(e.off);
        end else if (t.addr >= UB && t.addr < UB + US) begin
            e.off  = t.addr - UB;
            e.strb = t.we ? 4'b0010 : 4'b0001;
            if (!t.we) e.rdata = uart_fn(e.off);
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.size = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 11))
            0, 1, 2: t.addr = DB + ($urandom & 32'hFF);
            3, 4, 5: t.addr = UB + ($urandom & 32'hFF);
            6:       t.addr = $urandom;
            7:       t.addr = DB - 32'd1;
            8:       t.addr = DB + DS - 32'd1;
            9:       t.addr = DB + DS;
            10:      t.addr = UB + US - 32'd1;
            default: t.addr = UB + US;
        endcase
        return t;
    endfunction

    task automatic monitor(input int d, input logic [1:0] gnt, input logic [1:0] rv,
                           input logic [1:0] er, input logic [3:0] strb,
                           input logic [31:0] off, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [2:0] sz);
        exp_t e;
        bit   have;
        have = (d == 0) ? (sb_rr.size() > 0) : (sb_fp.size() > 0);
        e = '0;
        if (have) e = (d == 0) ? sb_rr[0] : sb_fp[0];
        chk("strobe_at_most_one", 32'($countones(strb) <= 1), 32'd1);
        if (gnt == 2'b00) begin
            chk("strobe_outside_access", 32'(strb), 32'd0);
        end else if (!have) begin
            fail_now("unexpected_gnt");
        end else begin
            chk("gnt", 32'(gnt), 32'(e.owner_oh));
            chk("strobes", 32'(strb), 32'(e.strb));
            chk("s_addr_off", off, e.off);
            chk("s_wdata", wd, e.wdata);
            chk("s_size", 32'(sz), 32'(e.size));
        end
        if (rv == 2'b00) begin
            chk("err_without_rvalid", 32'(er), 32'd0);
        end else if (!have) begin
            fail_now("unexpected_rvalid");
        end else begin
            chk("rvalid", 32'(rv), 32'(e.owner_oh));
            chk("rvalid_after_gnt", 32'(prev_gnt[d]), 32'(e.owner_oh));
            chk("m_rdata", rd, e.rdata);
            chk("m_err", 32'(er), e.err ? 32'(e.owner_oh) : 32'd0);
            if (d == 0) void'(sb_rr.pop_front());
            else void'(sb_fp.pop_front());
        end
        prev_gnt[d] = gnt;
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            monitor(0, bus_rr.m_gnt, bus_rr.m_rvalid, bus_rr.m_err,
                    {bus_rr.dmem_wr_en, bus_rr.dmem_rd_en, bus_rr.uart_wr_en, bus_rr.uart_rd_en},
                    bus_rr.s_addr_off, bus_rr.s_wdata, bus_rr.m_rdata, bus_rr.s_size);
            monitor(1, bus_fp.m_gnt, bus_fp.m_rvalid, bus_fp.m_err,
                    {bus_fp.dmem_wr_en, bus_fp.dmem_rd_en, bus_fp.uart_wr_en, bus_fp.uart_rd_en},
                    bus_fp.s_addr_off, bus_fp.s_wdata, bus_fp.m_rdata, bus_fp.s_size);
        end
    end

    task automatic present();
        bus_rr.m_req = {q1.size() > 0, q0.size() > 0};
        if (q0.size() > 0) begin
            bus_rr.m_we[0] = q0[0].we;   bus_rr.m0_addr = q0[0].addr;
            bus_rr.m0_wdata = q0[0].wdata; bus_rr.m0_size = q0[0].size;
        end
        if (q1.size() > 0) begin
            bus_rr.m_we[1] = q1[0].we;   bus_rr.m1_addr = q1[0].addr;
            bus_rr.m1_wdata = q1[0].wdata; bus_rr.m1_size = q1[0].size;
        end
    endtask

    // Serve the queued transactions of both masters on the round-robin DUT.
    task automatic run_round();
        int i0 = 0;
        int i1 = 0;
        int w;
        int cyc;
        bit first = 1'b1;
        while (i0 < q0.size() || i1 < q1.size()) begin
            if (i0 < q0.size() && i1 < q1.size()) w = ptr_m;
            else w = (i0 < q0.size()) ? 0 : 1;
            if (w == 0) begin sb_rr.push_back(predict(q0[i0], 0)); i0++; end
            else begin sb_rr.push_back(predict(q1[i1], 1)); i1++; end
            ptr_m = 1 - w;
        end
        @(negedge clk);
        present();
        cyc = 0;
        while ((q0.size() > 0 || q1.size() > 0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                chk("idle_to_access_latency", 32'(bus_rr.m_gnt != 2'b00), 32'd1);
                first = 1'b0;
            end
            if (bus_rr.m_gnt[0] && q0.size() > 0) void'(q0.pop_front());
            if (bus_rr.m_gnt[1] && q1.size() > 0) void'(q1.pop_front());
            present();
        end
        if (cyc >= 50) begin
            fail_now("round_timeout");
            q0.delete(); q1.delete();
            present();
        end
        cyc = 0;
        while (sb_rr.size() > 0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (sb_rr.size() > 0) begin
            fail_now("response_timeout");
            sb_rr.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int cyc;
        reset = 1'b0;
        bus_rr.m_req = '0; bus_rr.m_we = '0; bus_rr.m0_addr = '0; bus_rr.m1_addr = '0;
        bus_rr.m0_wdata = '0; bus_rr.m1_wdata = '0; bus_rr.m0_size = '0; bus_rr.m1_size = '0;
        bus_fp.m_req = '0; bus_fp.m_we = '0; bus_fp.m0_addr = '0; bus_fp.m1_addr = '0;
        bus_fp.m0_wdata = '0; bus_fp.m1_wdata = '0; bus_fp.m0_size = '0; bus_fp.m1_size = '0;
        prev_gnt[0] = '0; prev_gnt[1] = '0;
        #12;
        chk("reset_gnt", 32'(bus_rr.m_gnt), 32'd0);
        chk("reset_rvalid", 32'(bus_rr.m_rvalid), 32'd0);
        chk("reset_err", 32'(bus_rr.m_err), 32'd0);
        chk("reset_strobes", 32'({bus_rr.dmem_wr_en, bus_rr.dmem_rd_en, bus_rr.uart_wr_en,
                                  bus_rr.uart_rd_en}), 32'd0);
        chk("reset_rdata", bus_rr.m_rdata, 32'd0);
        chk("reset_s_addr_off", bus_rr.s_addr_off, 32'd0);
        chk("reset_s_wdata", bus_rr.s_wdata, 32'd0);
        chk("reset_s_size", 32'(bus_rr.s_size), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed: DMEM load, UART store, alternation, unmapped, region edges.
        q0.push_back(mk(1'b0, 32'h8000_0010, 32'h0, 3'b010));
        run_round();
        q1.push_back(mk(1'b1, 32'h8000_0204, 32'h0000_0041, 3'b010));
        run_round();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(1'b0, DB + 32'(i * 8), 32'h0, 3'b010));
            q1.push_back(mk(1'b0, UB + 32'(i * 8), 32'h0, 3'b010));
        end
        run_round();
        q0.push_back(mk(1'b0, 32'h0000_0100, 32'h0, 3'b010));
        run_round();
        q0.push_back(mk(1'b0, 32'h8000_00FF, 32'h0, 3'b000));
        q0.push_back(mk(1'b0, 32'h8000_0100, 32'h0, 3'b000));
        q1.push_back(mk(1'b0, 32'h8000_02FF, 32'h0, 3'b000));
        q1.push_back(mk(1'b1, 32'h8000_0300, 32'h1234_5678, 3'b000));
        run_round();

        for (int r = 0; r < 60; r++) begin
            int n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) q0.push_back(rand_txn());
            for (int k = 0; k < n1; k++) q1.push_back(rand_txn());
            run_round();
        end

        // Fixed priority: master 0 keeps re-requesting, master 1 waits until it stops.
        for (int i = 0; i < 4; i++)
            sb_fp.push_back(predict(mk(1'b0, DB + 32'(i * 4), 32'h0, 3'b010), 0));
        sb_fp.push_back(predict(mk(1'b0, UB + 32'd8, 32'h0, 3'b010), 1));
        @(negedge clk);
        bus_fp.m_we = 2'b00; bus_fp.m0_size = 3'b010; bus_fp.m1_size = 3'b010;
        bus_fp.m0_wdata = '0; bus_fp.m1_wdata = '0;
        bus_fp.m0_addr = DB; bus_fp.m1_addr = UB + 32'd8;
        bus_fp.m_req = 2'b11;
        n0 = 0;
        cyc = 0;
        while (bus_fp.m_req != 2'b00 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_fp.m_gnt[0]) begin
                n0++;
                if (n0 < 4) bus_fp.m0_addr = DB + 32'(n0 * 4);
                else bus_fp.m_req[0] = 1'b0;
            end
            if (bus_fp.m_gnt[1]) bus_fp.m_req[1] = 1'b0;
        end
        if (cyc >= 40) begin
            fail_now("fixed_prio_timeout");
            bus_fp.m_req = 2'b00;
        end
        cyc = 0;
        while (sb_fp.size() > 0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (sb_fp.size() > 0) begin
            fail_now("fixed_prio_response_timeout");
            sb_fp.delete();
        end

        // Async reset in the middle of an ACCESS cycle.
        mon_en = 1'b0;
        @(negedge clk);
        bus_rr.m_req = 2'b10; bus_rr.m_we = 2'b00; bus_rr.m1_addr = DB + 32'h20;
        @(posedge clk);
        #2;
        chk("abort_gnt_before", 32'(bus_rr.m_gnt), 32'd2);
        chk("abort_rd_en_before", 32'(bus_rr.dmem_rd_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_gnt_now", 32'(bus_rr.m_gnt), 32'd0);
        chk("abort_strobes_now", 32'({bus_rr.dmem_wr_en, bus_rr.dmem_rd_en, bus_rr.uart_wr_en,
                                      bus_rr.uart_rd_en}), 32'd0);
        bus_rr.m_req = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rvalid", 32'(bus_rr.m_rvalid), 32'd0);
            chk("abort_no_gnt", 32'(bus_rr.m_gnt), 32'd0);
        end
        ptr_m = 0;
        prev_gnt[0] = '0; prev_gnt[1] = '0;
        mon_en = 1'b1;
        q0.push_back(mk(1'b0, UB + 32'h10, 32'h0, 3'b010));
        q1.push_back(mk(1'b1, DB + 32'h30, 32'hCAFE_F00D, 3'b010));
        run_round();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
